// File: rtl/nn_pkg.sv
// Shared definitions for the backprop network: sequencer state encoding,
// Q6.10 fixed-point format and the parameter registers' initial constants.
package nn_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_INIT   = 3'd1,
        S_LOAD   = 3'd2,
        S_FF     = 3'd3,
        S_BP     = 3'd4,
        S_UPDATE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    localparam int WIDTH = 16;
    localparam int FRAC  = 10;

    localparam logic [WIDTH-1:0] INIT_B3_1 = 16'hFC00;  // -1.0
    localparam logic [WIDTH-1:0] INIT_B2_1 = 16'h0200;  //  0.5
    localparam logic [WIDTH-1:0] INIT_W2_1 = 16'h0400;  //  1.0
    localparam logic [WIDTH-1:0] INIT_W3_1 = 16'hFE00;  // -0.5

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nn_train_ctrl_if.sv
// Control bundle between the training sequencer and the network datapath,
// plus the sequencer's state for observation.
interface nn_train_ctrl_if
    import nn_pkg::*;
#(
    parameter int SW = 2,
    parameter int EW = 10
);
    // start/abort are single-cycle requests with no ready: each is acted on at
    // the edge where it is sampled high, abort winning over start. Every output
    // is a registered-state decode, valid for the whole cycle.
    logic          start;
    logic          abort;
    logic          select_initial;
    logic          select_update;
    logic          ff_en;
    logic          bp_en;
    logic [SW-1:0] sample_idx;
    logic [EW-1:0] epoch_cnt;
    logic          busy;
    logic          done;
    state_t        state;

    modport master (
        input  start, abort,
        output select_initial, select_update, ff_en, bp_en,
               sample_idx, epoch_cnt, busy, done, state
    );

    modport slave (
        output start, abort,
        input  select_initial, select_update, ff_en, bp_en,
               sample_idx, epoch_cnt, busy, done, state
    );
endinterface

// File: rtl/nn_phase_cnt.sv
// Loadable down-counter timing the feed-forward and backprop phases;
// zero marks the last cycle of the phase.
module nn_phase_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
endmodule

// File: rtl/nn_train_ctrl.sv
// Training sequencer: steps INIT -> (LOAD, FF, BP, UPDATE) per sample for
// every epoch, driving the shared parameter-register selects.
module nn_train_ctrl
    import nn_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int N_EPOCHS  = 1000,
    parameter int FF_CYCLES = 3,
    parameter int BP_CYCLES = 4
) (
    input  logic            clk,
    input  logic            reset,
    nn_train_ctrl_if.master bus
);
    localparam int SW        = cnt_w(N_SAMPLES);
    localparam int EW        = cnt_w(N_EPOCHS);
    localparam int PHASE_MAX = (FF_CYCLES > BP_CYCLES) ? FF_CYCLES : BP_CYCLES;
    localparam int CW        = cnt_w(PHASE_MAX);

    localparam logic [SW-1:0] S_LAST  = SW'(N_SAMPLES - 1);
    localparam logic [EW-1:0] E_LAST  = EW'(N_EPOCHS - 1);
    localparam logic [CW-1:0] FF_LOAD = CW'(FF_CYCLES - 1);
    localparam logic [CW-1:0] BP_LOAD = CW'(BP_CYCLES - 1);

    state_t        state, state_next;
    logic [SW-1:0] sample_idx;
    logic [EW-1:0] epoch_cnt;
    logic          ph_load, ph_zero;
    logic [CW-1:0] ph_val;

    nn_phase_cnt #(.W(CW)) u_phase_cnt (
        .clk     (clk),
        .reset   (reset),
        .load    (ph_load),
        .load_val(ph_val),
        .zero    (ph_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next         = state;
        ph_load            = 1'b0;
        ph_val             = '0;
        bus.select_initial = 1'b0;
        bus.select_update  = 1'b0;
        bus.ff_en          = 1'b0;
        bus.bp_en          = 1'b0;
        bus.busy           = 1'b0;
        bus.done           = 1'b0;

        if (bus.abort) begin
            state_next = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE:   if (bus.start) state_next = S_INIT;
                S_INIT:   state_next = S_LOAD;
                S_LOAD:   state_next = S_FF;
                S_FF:     if (ph_zero) state_next = S_BP;
                S_BP:     if (ph_zero) state_next = S_UPDATE;
                S_UPDATE: state_next = (sample_idx != S_LAST || epoch_cnt != E_LAST)
                                       ? S_LOAD : S_DONE;
                S_DONE:   if (bus.start) state_next = S_INIT;
                default:  state_next = S_IDLE;
            endcase
        end

        // Phase length is loaded on the entering edge so the first phase cycle already counts.
        if (state_next == S_FF && state != S_FF) begin
            ph_load = 1'b1;
            ph_val  = FF_LOAD;
        end else if (state_next == S_BP && state != S_BP) begin
            ph_load = 1'b1;
            ph_val  = BP_LOAD;
        end

        bus.select_initial = (state == S_INIT);
        bus.select_update  = (state == S_UPDATE);
        bus.ff_en          = (state == S_FF);
        bus.bp_en          = (state == S_BP);
        bus.done           = (state == S_DONE);
        bus.busy           = (state != S_IDLE) && (state != S_DONE);
    end

    // Counters read 0 in IDLE and in INIT, and hold their final values in DONE.
    always_ff @(posedge clk) begin
        if (reset || bus.abort || state_next == S_INIT) begin
            sample_idx <= '0;
            epoch_cnt  <= '0;
        end else if (state == S_UPDATE) begin
            if (sample_idx != S_LAST) begin
                sample_idx <= sample_idx + SW'(1);
            end else if (epoch_cnt != E_LAST) begin
                sample_idx <= '0;
                epoch_cnt  <= epoch_cnt + EW'(1);
            end
        end
    end

    assign bus.sample_idx = sample_idx;
    assign bus.epoch_cnt  = epoch_cnt;
    assign bus.state      = state;
endmodule
